// File: rtl/display_scan_ctrl.sv
// Converts a 16-bit binary value to four BCD digits (sequential double-dabble) and
// time-multiplexes them onto a shared 7-segment decoder. Optional macro: DISP_LZB_EN.
module display_scan_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [3:0]  digit_code,
    output logic [3:0]  digit_sel,
    output logic [1:0]  state_dbg
);

    // Handshake: load is accepted on a rising edge only while busy=0; a load seen
    // while busy=1 (including the COMMIT cycle) is dropped, never queued. done
    // pulses for exactly one cycle, in the cycle the new digits become visible.

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [15:0]       bin_q, bin_nx;
    logic [15:0]       bcd_q, bcd_nx;
    logic [15:0]       bcd_adj;
    logic [3:0]        bit_cnt, bit_cnt_nx;
    logic              ovf_q, ovf_nx;
    logic [3:0][3:0]   disp_q, disp_nx;
    logic              done_q, done_nx;
    logic [PW-1:0]     presc;
    logic [1:0]        idx;

    function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [15:0] commit_digits(input logic [15:0] b, input logic ovf);
        logic [15:0] r;
        r = b;
        if (ovf) begin
            r = 16'hEEEE;
        end
`ifdef DISP_LZB_EN
        else begin
            // Blank zeros above the highest nonzero digit; units always shown.
            logic lead;
            lead = 1'b1;
            for (int i = 3; i >= 1; i--) begin
                if (lead && (r[i*4 +: 4] == 4'd0))
                    r[i*4 +: 4] = 4'hF;
                else
                    lead = 1'b0;
            end
        end
`endif
        return r;
    endfunction

    always_comb begin
        state_nx   = state;
        bin_nx     = bin_q;
        bcd_nx     = bcd_q;
        bit_cnt_nx = bit_cnt;
        ovf_nx     = ovf_q;
        disp_nx    = disp_q;
        done_nx    = 1'b0;
        bcd_adj    = dabble_adjust(bcd_q);
        case (state)
            IDLE: begin
                if (load) begin
                    bin_nx     = value;
                    bcd_nx     = 16'd0;
                    bit_cnt_nx = 4'd0;
                    ovf_nx     = (value > 16'd9999);
                    state_nx   = CONV;
                end
            end
            CONV: begin
                {bcd_nx, bin_nx} = {bcd_adj[14:0], bin_q, 1'b0};
                bit_cnt_nx       = bit_cnt + 4'd1;
                if (bit_cnt == 4'd15)
                    state_nx = COMMIT;
            end
            COMMIT: begin
                disp_nx  = commit_digits(bcd_q, ovf_q);
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bin_q   <= 16'd0;
            bcd_q   <= 16'd0;
            bit_cnt <= 4'd0;
            ovf_q   <= 1'b0;
            disp_q  <= {4{4'hF}};
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            bin_q   <= bin_nx;
            bcd_q   <= bcd_nx;
            bit_cnt <= bit_cnt_nx;
            ovf_q   <= ovf_nx;
            disp_q  <= disp_nx;
            done_q  <= done_nx;
        end
    end

    // Scanner is free-running; a commit never resets its phase.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc <= '0;
            idx   <= 2'd0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign digit_code = disp_q[idx];
    assign digit_sel  = ~(4'b0001 << idx);
    assign busy       = (state != IDLE);
    assign done       = done_q;
    assign state_dbg  = state;

endmodule
